// File: rtl/unit_launch_ctl.sv
`default_nettype none
// ============================================================================
// Module   : unit_launch_ctl
// Brief    : Staggered reset-release / start sequencer for the unit array.
//            Latches the requested unit count on start, starts units one by
//            one every STAGGER cycles, tracks per-unit completion and drives
//            the aggregate busy back to dispatch.
//            Optional watchdog: define UNIT_LAUNCH_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module unit_launch_ctl #(
    parameter int NU        = 8,
    parameter int STAGGER   = 2,
    parameter int WDOG_BITS = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          reset_top,
    input  logic [7:0]    num_units,
    output logic          busy,
    output logic [NU-1:0] unit_reset,
    output logic [NU-1:0] unit_start,
    input  logic [NU-1:0] unit_busy,
    output logic          wdog_err
);

    // Elaboration-time range check of the configuration
    if (NU < 1 || NU > 64 || STAGGER < 1 || STAGGER > 15 || WDOG_BITS < 1) begin : g_param_check
        $error("unit_launch_ctl: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] C_RELOAD = 4'(STAGGER - 1);

    state_t        state_q, state_d;
    logic [6:0]    n_q, n_d;
    logic [6:0]    idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [NU-1:0] launched_q, launched_d;
    logic [NU-1:0] active_q, active_d;
    logic [NU-1:0] armed_q, armed_d;
    logic          busy_q, busy_d;
    logic [NU-1:0] unit_reset_q, unit_reset_d;
    logic [NU-1:0] unit_start_q, unit_start_d;
    logic          wdog_err_d;
    logic          wdog_trip;

    logic [6:0]    w_n;
    logic [NU-1:0] w_idx_oh;
    logic [6:0]    w_idx_inc;

    // Effective unit count, clamped to the physical array size
    assign w_n       = (num_units > 8'(NU)) ? 7'(NU) : num_units[6:0];
    assign w_idx_inc = idx_q + 7'd1;

    // One-hot decode of the unit currently being launched
    always_comb begin
        w_idx_oh = '0;
        for (int i = 0; i < NU; i++) begin
            w_idx_oh[i] = (idx_q == 7'(i));
        end
    end

`ifdef UNIT_LAUNCH_WDOG_EN
    localparam logic [WDOG_BITS-1:0] C_WDOG_MAX = '1;

    logic [WDOG_BITS-1:0] wdog_cnt_q, wdog_cnt_d;
    logic [NU-1:0]        bmask_q;
    logic [NU-1:0]        w_bmask;
    logic                 w_change;
    logic                 wdog_err_q;

    assign w_bmask  = unit_busy & launched_q;
    assign w_change = (w_bmask != bmask_q);

    // Watchdog: counts RUN cycles without any busy activity on launched units
    always_comb begin
        wdog_cnt_d = '0;
        wdog_err_d = 1'b0;
        wdog_trip  = 1'b0;
        if (state_q == S_RUN) begin
            if (wdog_cnt_q == C_WDOG_MAX) begin
                wdog_trip  = 1'b1;
                wdog_cnt_d = wdog_cnt_q;
            end else if (w_change) begin
                wdog_cnt_d = '0;
            end else begin
                wdog_cnt_d = wdog_cnt_q + 1'b1;
                // Pulse as the counter reaches saturation; the trip follows
                wdog_err_d = (wdog_cnt_d == C_WDOG_MAX) && !reset_top;
            end
        end
    end

    // Watchdog state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt_q <= '0;
            bmask_q    <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            bmask_q    <= w_bmask;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_err_d = 1'b0;
    assign wdog_trip  = 1'b0;
    assign wdog_err   = 1'b0;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        launched_d   = launched_q;
        armed_d      = armed_q | unit_start_q;
        active_d     = active_q & ~(armed_q & ~unit_busy);
        unit_start_d = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d        = w_n;
                    launched_d = '0;
                    active_d   = '0;
                    armed_d    = '0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    if (w_n == 7'd0) begin
                        state_d = S_DONE;
                    end else begin
                        // Unit 0 launches on the start edge itself so that its
                        // start pulse lands in the cycle right after start.
                        launched_d[0]   = 1'b1;
                        active_d[0]     = 1'b1;
                        unit_start_d[0] = 1'b1;
                        idx_d           = 7'd1;
                        cnt_d           = C_RELOAD;
                        state_d         = (w_n == 7'd1) ? S_RUN : S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (cnt_q == 4'd0) begin
                    launched_d   = launched_d | w_idx_oh;
                    active_d     = active_d | w_idx_oh;
                    unit_start_d = w_idx_oh;
                    cnt_d        = C_RELOAD;
                    idx_d        = w_idx_inc;
                    if (w_idx_inc == n_q) begin
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RUN: begin
                if (active_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog expiry: hold every unit in reset and close the job
        if (wdog_trip) begin
            state_d    = S_DONE;
            launched_d = '0;
            active_d   = '0;
            armed_d    = '0;
        end

        // Dispatch going idle mid-job aborts everything
        if (state_q != S_IDLE && reset_top) begin
            state_d      = S_IDLE;
            launched_d   = '0;
            active_d     = '0;
            armed_d      = '0;
            unit_start_d = '0;
        end

        busy_d       = (state_d != S_IDLE);
        unit_reset_d = {NU{reset_top}} | ~launched_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            launched_q   <= '0;
            active_q     <= '0;
            armed_q      <= '0;
            busy_q       <= 1'b0;
            unit_reset_q <= '1;
            unit_start_q <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            launched_q   <= launched_d;
            active_q     <= active_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            unit_reset_q <= unit_reset_d;
            unit_start_q <= unit_start_d;
        end
    end

    assign busy       = busy_q;
    assign unit_reset = unit_reset_q;
    assign unit_start = unit_start_q;

endmodule
`default_nettype wire

// File: tb/tb_unit_launch_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_unit_launch_ctl
// Brief    : Directed self-checking bench for unit_launch_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unit_launch_ctl;

    localparam int NU        = 8;
    localparam int STAGGER   = 2;
    localparam int WDOG_BITS = 6;
    localparam int UNIT_LEN  = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          reset_top;
    logic [7:0]    num_units;
    logic          busy;
    logic [NU-1:0] unit_reset;
    logic [NU-1:0] unit_start;
    logic [NU-1:0] unit_busy;
    logic          wdog_err;
    logic [NU-1:0] stuck;
    int            mcnt [NU];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    unit_launch_ctl #(
        .NU        (NU),
        .STAGGER   (STAGGER),
        .WDOG_BITS (WDOG_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .reset_top  (reset_top),
        .num_units  (num_units),
        .busy       (busy),
        .unit_reset (unit_reset),
        .unit_start (unit_start),
        .unit_busy  (unit_busy),
        .wdog_err   (wdog_err)
    );

    // Unit model: busy for UNIT_LEN cycles starting the cycle after its start
    always @(posedge clk) begin
        for (int i = 0; i < NU; i++) begin
            if (reset)              mcnt[i] <= 0;
            else if (unit_start[i]) mcnt[i] <= UNIT_LEN;
            else if (mcnt[i] != 0)  mcnt[i] <= mcnt[i] - 1;
        end
    end

    always_comb begin
        unit_busy = stuck;
        for (int i = 0; i < NU; i++) begin
            if (mcnt[i] != 0) unit_busy[i] = 1'b1;
        end
    end

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; reset_top = 1'b0; num_units = 8'd0; stuck = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++; if (unit_reset !== 8'hFF) begin n_fail++; $display("FAIL reset_unit_reset k=%0d got %h want ff", k, unit_reset); end
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy k=%0d got %b want 0", k, busy); end
            n_cmp++; if (unit_start !== 8'h00) begin n_fail++; $display("FAIL reset_unit_start k=%0d got %h want 00", k, unit_start); end
            n_cmp++; if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL reset_wdog k=%0d got %b want 0", k, wdog_err); end
        end
    endtask

    // Launch scenario: req requested units, neff expected after clamping
    task automatic test_launch(input string tag, input int req, input int neff, input int kmax);
        logic [NU-1:0] es, lm;
        logic          eb;
        int            last_s, fall_ub, fall_busy;
        last_s    = 1 + STAGGER * (neff - 1);
        fall_ub   = -1;
        fall_busy = -1;
        @(negedge clk);
        num_units = 8'(req);
        start     = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            start = 1'b0;
            es = '0;
            lm = '0;
            for (int j = 0; j < neff; j++) begin
                if (k == 1 + STAGGER * j) es[j] = 1'b1;
                if (k >= 1 + STAGGER * j) lm[j] = 1'b1;
            end
            eb = (k <= last_s + UNIT_LEN + 2);
            n_cmp++; if (unit_start !== es) begin n_fail++; $display("FAIL %s_unit_start k=%0d got %h want %h", tag, k, unit_start, es); end
            n_cmp++; if (unit_reset !== ~lm) begin n_fail++; $display("FAIL %s_unit_reset k=%0d got %h want %h", tag, k, unit_reset, ~lm); end
            n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL %s_busy k=%0d got %b want %b", tag, k, busy, eb); end
            if (fall_ub < 0 && k > last_s + 1 && !unit_busy[neff-1]) fall_ub = k;
            if (fall_busy < 0 && !busy) fall_busy = k;
        end
        n_cmp++; if (fall_busy - fall_ub !== 2) begin n_fail++; $display("FAIL %s_busy_fall_delay got %0d want 2", tag, fall_busy - fall_ub); end
    endtask

    task automatic test_zero();
        @(negedge clk);
        num_units = 8'd0;
        start     = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++; if (busy !== (k == 1)) begin n_fail++; $display("FAIL zero_busy k=%0d got %b want %b", k, busy, (k == 1)); end
            n_cmp++; if (unit_start !== 8'h00) begin n_fail++; $display("FAIL zero_unit_start k=%0d got %h want 00", k, unit_start); end
        end
    endtask

    task automatic test_abort();
        logic [NU-1:0] es, er;
        @(negedge clk);
        num_units = 8'd8;
        start     = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            es = (k == 1) ? 8'h01 : (k == 3) ? 8'h02 : 8'h00;
            er = (k <= 2) ? 8'hFE : (k <= 4) ? 8'hFC : 8'hFF;
            n_cmp++; if (unit_start !== es) begin n_fail++; $display("FAIL abort_unit_start k=%0d got %h want %h", k, unit_start, es); end
            n_cmp++; if (unit_reset !== er) begin n_fail++; $display("FAIL abort_unit_reset k=%0d got %h want %h", k, unit_reset, er); end
            n_cmp++; if (busy !== (k <= 4)) begin n_fail++; $display("FAIL abort_busy k=%0d got %b want %b", k, busy, (k <= 4)); end
            start     = (k == 2);
            reset_top = (k >= 4 && k <= 6);
        end
        start     = 1'b0;
        reset_top = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic test_stuck();
        @(negedge clk);
        stuck     = 8'h01;
        num_units = 8'd1;
        start     = 1'b1;
`ifdef UNIT_LAUNCH_WDOG_EN
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++; if (wdog_err !== (k == 65)) begin n_fail++; $display("FAIL wdog_err k=%0d got %b want %b", k, wdog_err, (k == 65)); end
            n_cmp++; if (busy !== (k <= 66)) begin n_fail++; $display("FAIL wdog_busy k=%0d got %b want %b", k, busy, (k <= 66)); end
            if (k >= 66) begin
                n_cmp++; if (unit_reset !== 8'hFF) begin n_fail++; $display("FAIL wdog_unit_reset k=%0d got %h want ff", k, unit_reset); end
            end
        end
        stuck = '0;
`else
        for (int k = 1; k <= 102; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++; if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL stuck_wdog k=%0d got %b want 0", k, wdog_err); end
            n_cmp++; if (busy !== (k <= 101)) begin n_fail++; $display("FAIL stuck_busy k=%0d got %b want %b", k, busy, (k <= 101)); end
            if (k == 100) stuck = '0;
        end
`endif
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_launch("three", 3, 3, 32);
        test_launch("clamp", 200, 8, 42);
        test_zero();
        test_abort();
        test_stuck();
        test_launch("again", 2, 2, 28);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
